mux_skid_stage: RTL and testbench

MUX_SKID_STAGE -- requirements
Module: mux_skid_stage

---
 rtl/mux_skid_stage_if.sv | 36 +++
 rtl/mux_skid_stage.sv | 126 ++++++++++++
 tb/tb_mux_skid_stage.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mux_skid_stage_if.sv
// -----------------------------------------------------------------------------
// mux_skid_stage_if
// Bundles the input handshake (in_bus/sel/in_valid/in_ready) and the output
// handshake (out_data/out_valid/out_ready) of mux_skid_stage.
//
// Parameters: K  data width per channel
//             N  number of input channels
//             SW select width, ceil(log2(N))
//
// Modports:
//   slave  - the stage itself (consumes in_*, out_ready; produces the rest)
//   master - the environment around the stage (upstream and downstream)
// -----------------------------------------------------------------------------
interface mux_skid_stage_if #(
  parameter int K  = 32,
  parameter int N  = 4,
  parameter int SW = 2
);
  logic [N*K-1:0] in_bus;
  logic [SW-1:0]  sel;
  logic           in_valid;
  logic           in_ready;
  logic [K-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;

  modport slave (
    input  in_bus, sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_bus, sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/mux_skid_stage.sv
// -----------------------------------------------------------------------------
// mux_skid_stage
// N-to-1 channel select followed by a two-entry skid buffer (OUT + SKID).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 on the same side. in_ready and out_valid come straight from flops,
// so neither depends combinationally on out_ready or in_valid.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset (priority over flush)
//   flush      synchronous kill: empties the stage, drops any offered input
//   bus        mux_skid_stage_if.slave (in_bus, sel, in_valid, in_ready,
//              out_data, out_valid, out_ready)
//   state_dbg  current FSM state (0 EMPTY, 1 ONE, 2 TWO)
//
// N must be 2..8 and SW must equal ceil(log2(N)). A sel value >= N selects
// channel 0.
// -----------------------------------------------------------------------------
module mux_skid_stage #(
  parameter int K  = 32,
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  mux_skid_stage_if.slave     bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [K-1:0] out_q, out_d;
  logic [K-1:0] skid_q, skid_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;

  logic [K-1:0] sel_word;
  logic         in_xfer;
  logic         out_xfer;

  // Channel 0 is the default so that out-of-range selects fall back to it.
  always_comb begin
    sel_word = bus.in_bus[K-1:0];
    for (int i = 1; i < N; i++) begin
      if (bus.sel == SW'(i)) begin
        sel_word = bus.in_bus[i*K +: K];
      end
    end
  end

  assign in_xfer  = bus.in_valid & in_ready_q;
  assign out_xfer = out_valid_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;

    if (flush) begin
      // Data registers are left alone; they are don't-care while empty.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_ONE;
            out_d   = sel_word;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            out_d = sel_word;
          end else if (in_xfer) begin
            state_d = ST_TWO;
            skid_d  = sel_word;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the output side can move.
          if (out_xfer) begin
            state_d = ST_ONE;
            out_d   = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end

    // Handshake flags are registered copies of the next-state decode.
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.out_data  = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_mux_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_mux_skid_stage
// Table-driven directed vectors and hand sequences on an N=4 instance, an
// out-of-range select check on an N=3 instance, then a random run against a
// queue-based reference model of the stage.
// -----------------------------------------------------------------------------
module tb_mux_skid_stage;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst, flush;
  logic rst3, flush3;
  logic [1:0] state_dbg, state_dbg3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux_skid_stage_if #(.K(32), .N(4), .SW(2)) b4 ();
  mux_skid_stage_if #(.K(32), .N(3), .SW(2)) b3 ();

  mux_skid_stage #(.K(32), .N(4), .SW(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(b4), .state_dbg(state_dbg)
  );

  mux_skid_stage #(.K(32), .N(3), .SW(2)) dut3 (
    .clk(clk), .rst(rst3), .flush(flush3), .bus(b3), .state_dbg(state_dbg3)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec;
  int n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drives one cycle on the N=4 instance. While inputs are stable it flips
  // out_ready and confirms in_ready does not move with it.
  task automatic cycle4(input logic r, input logic f, input logic v,
                        input logic [1:0] s, input logic o, input logic [127:0] b);
    logic ir_a;
    @(negedge clk);
    rst = r; flush = f;
    b4.in_valid = v; b4.sel = s; b4.out_ready = o; b4.in_bus = b;
    #1;
    ir_a = b4.in_ready;
    b4.out_ready = ~o;
    #1;
    chk("in_ready_vs_out_ready", {31'd0, b4.in_ready}, {31'd0, ir_a});
    b4.out_ready = o;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle3(input logic r, input logic v, input logic [1:0] s, input logic o);
    @(negedge clk);
    rst3 = r; flush3 = 1'b0;
    b3.in_valid = v; b3.sel = s; b3.out_ready = o;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r, f, v;
    logic [1:0]  s;
    logic        o;
    logic        ov, ir, cd;
    logic [31:0] d;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic v,
                              input logic [1:0] s, input logic o,
                              input logic ov, input logic ir, input logic cd,
                              input logic [31:0] d);
    vec_t t;
    t.r = r; t.f = f; t.v = v; t.s = s; t.o = o;
    t.ov = ov; t.ir = ir; t.cd = cd; t.d = d;
    return t;
  endfunction

  localparam logic [127:0] FIXED_BUS =
    {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

  vec_t vecs[17];

  // ---------------- reference model ----------------
  logic [31:0] model_q[$];

  function automatic logic [31:0] pick(input logic [127:0] b, input int idx, input int n);
    int k;
    k = (idx < n) ? idx : 0;
    return 32'((b >> (k * 32)) & 128'hFFFF_FFFF);
  endfunction

  initial begin
    logic [127:0] rb;
    logic         rr, rf, rv, ro;
    logic [1:0]   rs;
    logic         m_ir, m_ov;
    logic [31:0]  w;
    logic         just_reset;

    n_vec = 0;
    n_err = 0;
    rst = 1'b1; flush = 1'b0;
    rst3 = 1'b1; flush3 = 1'b0;
    b4.in_valid = 1'b0; b4.sel = '0; b4.out_ready = 1'b0; b4.in_bus = '0;
    b3.in_valid = 1'b0; b3.sel = '0; b3.out_ready = 1'b0;
    b3.in_bus = {32'hCCCC2222, 32'hBBBB1111, 32'hAAAA0000};

    //          r     f     v     sel   o     ov    ir    cd    data
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);        // reset
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);        // idle after reset
    vecs[2]  = mk(1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h33333333); // select ch2
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);        // drained
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11111111); // A -> OUT
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111); // B -> SKID
    vecs[6]  = mk(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111); // C held
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h22222222); // A out
    vecs[8]  = mk(1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h33333333); // B out, C in
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);        // C out
    vecs[10] = mk(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11111111);
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111); // TWO
    vecs[12] = mk(1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);        // flush in TWO
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);        // nothing appears
    vecs[14] = mk(1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 32'h44444444); // select ch3
    vecs[15] = mk(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);        // rst+flush mid-item
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);

    for (int i = 0; i < 17; i++) begin
      cycle4(vecs[i].r, vecs[i].f, vecs[i].v, vecs[i].s, vecs[i].o, FIXED_BUS);
      chk($sformatf("vec%0d_out_valid", i), {31'd0, b4.out_valid}, {31'd0, vecs[i].ov});
      chk($sformatf("vec%0d_in_ready", i), {31'd0, b4.in_ready}, {31'd0, vecs[i].ir});
      if (vecs[i].cd) chk($sformatf("vec%0d_out_data", i), b4.out_data, vecs[i].d);
    end

    // ---------------- N=3 instance: out-of-range select ----------------
    cycle3(1'b1, 1'b0, 2'd0, 1'b1);
    chk("n3_reset_out_valid", {31'd0, b3.out_valid}, 32'd0);
    cycle3(1'b0, 1'b1, 2'd3, 1'b1);
    chk("n3_sel3_out_valid", {31'd0, b3.out_valid}, 32'd1);
    chk("n3_sel3_data", b3.out_data, 32'hAAAA0000);
    cycle3(1'b0, 1'b1, 2'd2, 1'b1);
    chk("n3_sel2_data", b3.out_data, 32'hCCCC2222);
    cycle3(1'b0, 1'b1, 2'd1, 1'b1);
    chk("n3_sel1_data", b3.out_data, 32'hBBBB1111);
    cycle3(1'b0, 1'b0, 2'd0, 1'b1);
    chk("n3_drain_out_valid", {31'd0, b3.out_valid}, 32'd0);

    // ---------------- random run vs reference model ----------------
    cycle4(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, '0);
    model_q.delete();
    for (int c = 0; c < 1500; c++) begin
      rb = {$urandom, $urandom, $urandom, $urandom};
      rr = ($urandom_range(0, 99) == 0);
      rf = ($urandom_range(0, 29) == 0);
      rv = ($urandom_range(0, 99) < 65);
      ro = ($urandom_range(0, 99) < 60);
      rs = 2'($urandom_range(0, 3));

      m_ir = (model_q.size() < 2);
      m_ov = (model_q.size() > 0);
      w    = pick(rb, int'(rs), 4);

      cycle4(rr, rf, rv, rs, ro, rb);

      just_reset = rr;
      if (rr || rf) begin
        model_q.delete();
      end else begin
        if (m_ov && ro) void'(model_q.pop_front());
        if (rv && m_ir) model_q.push_back(w);
      end

      chk("rand_out_valid", {31'd0, b4.out_valid}, {31'd0, model_q.size() > 0});
      chk("rand_in_ready", {31'd0, b4.in_ready}, {31'd0, model_q.size() < 2});
      if (model_q.size() > 0) chk("rand_out_data", b4.out_data, model_q[0]);
      else if (just_reset) chk("rand_reset_data", b4.out_data, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
